// File: rtl/skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | skid_reg : registered valid/ready stage with a one-entry skid buffer and   |
// |            a wrapping delivered-beat counter; every output is a flop.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module skid_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_level;
  logic [CNT_W-1:0] r_count;

  logic w_in_acc;
  logic w_out_acc;
  logic w_main_from_in;
  logic w_main_from_skid;
  logic w_skid_load;

  assign w_in_acc  = in_valid & r_in_ready;
  assign w_out_acc = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_acc) begin
          w_main_from_in = 1'b1;
          w_state_nxt    = S_ONE;
        end
      end
      S_ONE: begin
        if (w_in_acc && w_out_acc) begin
          w_main_from_in = 1'b1;
        end else if (w_in_acc) begin
          w_skid_load = 1'b1;
          w_state_nxt = S_FULL;
        end else if (w_out_acc) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_out_acc) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Flag outputs are registered copies of the next state so no output is decoded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_level     <= 2'd0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      r_level     <= w_state_nxt;
      if (w_main_from_in) begin
        r_main <= in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_load) begin
        r_skid <= in_data;
      end
      if (w_out_acc) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_main;
  assign level      = r_level;
  assign xfer_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_skid_reg : randomized and directed bench for skid_reg against a queue   |
// |               model; a second instance with CNT_W=2 checks counter wrap.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_skid_reg;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;

  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       level;
  logic [7:0]       xfer_count;

  logic             in_ready2, out_valid2;
  logic [WIDTH-1:0] out_data2;
  logic [1:0]       level2;
  logic [1:0]       xfer_count2;

  always #5 clk = ~clk;

  skid_reg #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .xfer_count(xfer_count)
  );

  skid_reg #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
    .level(level2), .xfer_count(xfer_count2)
  );

  int total = 0;
  int bad   = 0;

  // Model: the stage is a FIFO of depth two; head is what out_data shows.
  logic [WIDTH-1:0] m_q[$];
  int               m_cnt = 0;
  bit               m_in_acc = 1'b0;
  logic [WIDTH-1:0] dlv[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("in_ready",    32'(in_ready),    32'(m_q.size() < 2));
    check("out_valid",   32'(out_valid),   32'(m_q.size() > 0));
    check("level",       32'(level),       32'(m_q.size()));
    check("xfer_count",  32'(xfer_count),  32'(m_cnt % 256));
    check("level2",      32'(level2),      32'(m_q.size()));
    check("xfer_count2", 32'(xfer_count2), 32'(m_cnt % 4));
    if (m_q.size() > 0) begin
      check("out_data",  32'(out_data),  32'(m_q[0]));
      check("out_data2", 32'(out_data2), 32'(m_q[0]));
    end
  endtask

  task automatic step(input bit rst, input bit iv, input logic [WIDTH-1:0] id, input bit ordy);
    bit ia, oa;
    reset     = rst;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    if (!rst && out_valid && ordy) dlv.push_back(out_data);
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_cnt    = 0;
      m_in_acc = 1'b0;
    end else begin
      ia = iv && (m_q.size() < 2);
      oa = ordy && (m_q.size() > 0);
      m_in_acc = ia;
      if (oa) begin
        void'(m_q.pop_front());
        m_cnt++;
      end
      if (ia) m_q.push_back(id);
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin : main
    int exp2[5];
    bit sent5;
    int seq;
    exp2 = '{1, 2, 3, 0, 1};

    // Reset while a beat is offered
    step(1'b1, 1'b1, 4'hA, 1'b0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // Full-rate stream 1..8
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, WIDTH'(i), 1'b1);
      check("stream_data",  32'(out_data), 32'(i));
      check("stream_level", 32'(level),    32'd1);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    check("stream_cnt", 32'(xfer_count), 32'd8);

    // Back-pressure fills main and skid; 5 must wait
    step(1'b1, 1'b0, '0, 1'b0);
    dlv.delete();
    step(1'b0, 1'b1, 4'd3, 1'b0);
    step(1'b0, 1'b1, 4'd4, 1'b0);
    check("bp_level",    32'(level),    32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 4'd5, 1'b0);
    check("bp_5_refused", 32'(m_in_acc), 32'd0);
    check("bp_main",      32'(out_data), 32'd3);
    sent5 = 1'b0;
    for (int c = 0; c < 10 && dlv.size() < 3; c++) begin
      step(1'b0, !sent5, 4'd5, 1'b1);
      if (m_in_acc) sent5 = 1'b1;
    end
    check("bp_count", 32'(dlv.size()), 32'd3);
    if (dlv.size() == 3) begin
      check("bp_order0", 32'(dlv[0]), 32'd3);
      check("bp_order1", 32'(dlv[1]), 32'd4);
      check("bp_order2", 32'(dlv[2]), 32'd5);
    end

    // Random traffic, sequence-numbered beats
    step(1'b1, 1'b0, '0, 1'b0);
    seq = 0;
    for (int c = 0; c < 8000 && m_cnt < 1000; c++) begin
      step(1'b0, 1'($urandom % 2), WIDTH'(seq), 1'($urandom % 2));
      if (m_in_acc) seq++;
    end
    check("rand_delivered", 32'(m_cnt >= 1000), 32'd1);
    check("rand_cnt",       32'(xfer_count),    32'(m_cnt % 256));

    // Reset while FULL discards held beats
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 4'd6, 1'b0);
    step(1'b0, 1'b1, 4'd7, 1'b0);
    check("full_level", 32'(level), 32'd2);
    step(1'b1, 1'b0, '0, 1'b1);
    check("rstfull_valid", 32'(out_valid), 32'd0);
    check("rstfull_level", 32'(level),     32'd0);
    dlv.delete();
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    check("rstfull_nobeats", 32'(dlv.size()), 32'd0);

    // 2-bit counter wrap
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      step(1'b0, k < 5, WIDTH'(k + 1), 1'b1);
      if (k >= 1) check("cnt2_wrap", 32'(xfer_count2), 32'(exp2[k-1]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
